// File: rtl/led_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : led_seq_ctrl
//  Description : Four-mode LED pattern sequencer (OFF / WALK / BLINK / COUNT)
//                stepped by a prescaled tick. A level mode request is taken
//                with a one-cycle registered acknowledge.
//  Config      : LED_SEQ_PWM_EN - adds a duty[3:0] input and a free-running
//                4-bit PWM counter that dims the LED outputs.
//  Ports       : clk_125  - 125 MHz system clock (rising edge)
//                rst      - asynchronous active-high reset
//                mode_req - mode change request, held until mode_ack
//                mode_sel - requested mode (0 OFF,1 WALK,2 BLINK,3 COUNT)
//                pause    - freezes prescaler and pattern while high
//                duty     - PWM duty 0..15 (LED_SEQ_PWM_EN only)
//                mode_ack - one-cycle acceptance pulse
//                cur_mode - active mode
//                led      - LED drive, active-high
//  Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
   parameter int unsigned TICK_DIV = 62500000
) (
   input  logic       clk_125,
   input  logic       rst,
   input  logic       mode_req,
   input  logic [1:0] mode_sel,
   input  logic       pause,
`ifdef LED_SEQ_PWM_EN
   input  logic [3:0] duty,
`endif
   output logic       mode_ack,
   output logic [1:0] cur_mode,
   output logic [3:0] led
);

   localparam logic [1:0]  c_MODE_OFF   = 2'd0;
   localparam logic [1:0]  c_MODE_WALK  = 2'd1;
   localparam logic [1:0]  c_MODE_BLINK = 2'd2;
   localparam logic [1:0]  c_MODE_COUNT = 2'd3;
   localparam logic [26:0] c_TICK_LAST  = 27'(TICK_DIV - 1);

   logic [1:0]  mode_q, mode_d;
   logic [3:0]  pat_q,  pat_d;
   logic [26:0] cnt_q,  cnt_d;
   logic        ack_q,  ack_d;
   logic        w_tick;
   logic        w_accept;

   // Initial pattern loaded whenever a mode is (re)entered.
   function automatic logic [3:0] f_init(input logic [1:0] m);
      case (m)
         c_MODE_WALK:  f_init = 4'b0001;
         c_MODE_BLINK: f_init = 4'b1111;
         default:      f_init = 4'b0000;
      endcase
   endfunction

   // Pattern after one tick in the given mode.
   function automatic logic [3:0] f_step(input logic [1:0] m, input logic [3:0] p);
      case (m)
         c_MODE_WALK:  f_step = {p[2:0], p[3]};
         c_MODE_BLINK: f_step = ~p;
         c_MODE_COUNT: f_step = p + 4'd1;
         default:      f_step = 4'b0000;
      endcase
   endfunction

   assign w_tick   = (cnt_q == c_TICK_LAST) && !pause;
   // ack_q blocks a held request for one cycle, giving one acceptance per two cycles.
   assign w_accept = mode_req && !ack_q;

   // ---------------------------------------------------------------- next state
   always_comb begin
      mode_d = mode_q;
      pat_d  = pat_q;
      cnt_d  = cnt_q;
      ack_d  = 1'b0;
      if (w_accept) begin
         // Acceptance overrides a coincident tick and ignores pause.
         mode_d = mode_sel;
         pat_d  = f_init(mode_sel);
         cnt_d  = '0;
         ack_d  = 1'b1;
      end else if (!pause) begin
         if (w_tick) begin
            cnt_d = '0;
            pat_d = f_step(mode_q, pat_q);
         end else begin
            cnt_d = cnt_q + 27'd1;
         end
      end
   end

`ifdef LED_SEQ_PWM_EN
   logic [3:0] pwm_q;
   logic [3:0] led_q;
   logic [3:0] w_led_d;

   // Gate the next pattern so the dimmed drive is itself a register output.
   assign w_led_d = pat_d & {4{pwm_q < duty}};
`endif

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst) begin
         mode_q <= c_MODE_OFF;
         pat_q  <= 4'b0000;
         cnt_q  <= '0;
         ack_q  <= 1'b0;
`ifdef LED_SEQ_PWM_EN
         pwm_q  <= 4'd0;
         led_q  <= 4'b0000;
`endif
      end else begin
         mode_q <= mode_d;
         pat_q  <= pat_d;
         cnt_q  <= cnt_d;
         ack_q  <= ack_d;
`ifdef LED_SEQ_PWM_EN
         pwm_q  <= pwm_q + 4'd1;
         led_q  <= w_led_d;
`endif
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      mode_ack = ack_q;
      cur_mode = mode_q;
`ifdef LED_SEQ_PWM_EN
      led      = led_q;
`else
      led      = pat_q;
`endif
   end

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 62500000, clk_125 cycles per pattern step (0.5 s at 125 MHz); legal range 2 to 2^27-1.
REQ-002 clk_125  input  1  system clock, 125 MHz; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mode_req  input  1  mode change request, level, held by requester until mode_ack.
REQ-005 mode_sel  input  2  requested mode: 0 OFF, 1 WALK, 2 BLINK, 3 COUNT; valid while mode_req high.
REQ-006 pause  input  1  level; freezes prescaler and pattern while high.
REQ-007 mode_ack  output  1  one-cycle acceptance pulse, registered.
REQ-008 cur_mode  output  2  currently active mode, registered.
REQ-009 led  output  4  board LED drive, registered, active-high.

Function
REQ-010 Prescaler: counter 0..TICK_DIV-1; tick asserted internally when count = TICK_DIV-1 and pause low; counter wraps to 0 on that edge.
REQ-011 pause high: prescaler and pattern hold value; tick never asserted.
REQ-012 Acceptance: at a rising edge with mode_req=1 and mode_ack=0, cur_mode <= mode_sel, pattern <= init value of that mode, prescaler <= 0, mode_ack <= 1.
REQ-013 mode_ack SHALL be high for exactly one cycle per acceptance; a request held through ack is re-accepted at the following edge (at most one acceptance per two cycles).
REQ-014 Acceptance SHALL be processed regardless of pause; pause still freezes subsequent stepping.
REQ-015 Acceptance and tick on the same edge: acceptance wins; tick discarded.
REQ-016 Re-selecting the active mode SHALL restart it (init pattern, prescaler 0).
REQ-017 State OFF: pattern 0000 constant; tick has no effect.
REQ-018 State WALK: init 0001; each tick rotate left by one; 1000 -> 0001.
REQ-019 State BLINK: init 1111; each tick bitwise invert (1111 <-> 0000).
REQ-020 State COUNT: init 0000; each tick +1 modulo 16; 1111 -> 0000.
REQ-021 Mode transitions occur only via acceptance (any state to any state); no other state changes.
REQ-022 led SHALL equal the pattern register (no combinational path from inputs to led), subject to REQ-027.
REQ-023 Step latency: pattern changes on the edge where tick is asserted; led reflects it the same cycle it is registered.

Reset
REQ-024 rst high SHALL immediately clear: cur_mode=OFF, pattern=0000, led=0000, prescaler=0, mode_ack=0, PWM counter=0.
REQ-025 rst asserted mid-step or mid-handshake SHALL discard any pending request; first acceptance possible at first rising edge after rst deasserts with mode_req high.
REQ-026 After reset, block stays in OFF until a request is accepted.

Configuration
REQ-027 Macro LED_SEQ_PWM_EN defined: extra input duty[3:0]; free-running 4-bit PWM counter incrementing every clk_125 cycle, wrapping 15->0; led = pattern AND {4{pwm_cnt < duty}}; duty 0 = dark, duty 15 = 15/16 on.
REQ-028 LED_SEQ_PWM_EN undefined: no duty port, no PWM counter; led = pattern exactly.

Verification (TICK_DIV=4)
REQ-029 Reset then no requests for 40 cycles -> led=0000, cur_mode=0, mode_ack never high.
REQ-030 Request WALK (mode_sel=1) held until ack -> mode_ack high one cycle, led=0001, then 0010, 0100, 1000, 0001 every 4 cycles.
REQ-031 COUNT selected, run 64 cycles -> led 0000..1111 then wraps to 0000; pause high for 10 cycles mid-run -> led frozen, prescaler resumes from held count.
REQ-032 BLINK active, new request COUNT issued on exact tick edge -> led=0000 (COUNT init), next change to 0001 exactly 4 cycles later, no BLINK toggle.
REQ-033 rst pulsed mid-WALK while mode_req high -> led=0000 and mode_ack=0 asynchronously; after release, acceptance on first edge, mode_ack one cycle.
REQ-034 With LED_SEQ_PWM_EN, BLINK at 1111, duty=4 -> each led bit high 4 of every 16 cycles; duty=0 -> led=0000 constantly.
